// File: rtl/clk_prog_seq.sv
// Serial programming sequencer for DCM_CLKGEN-style clock generators.
// Takes one (channel, M, D) request at a time, shifts LoadD / LoadM / GO to the
// selected generator over PROGEN/PROGDATA/PROGCLK, then waits for its PROGDONE.
module clk_prog_seq #(
  parameter int unsigned N_CLOCKS = 4,
  parameter int unsigned TIMEOUT  = 65535,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_chan,
  input  logic [7:0]          req_m,
  input  logic [7:0]          req_d,
  output logic [N_CLOCKS-1:0] progen,
  output logic                progdata,
  output logic                progclk,
  input  logic [N_CLOCKS-1:0] progdone,
  output logic                busy,
  output logic                done,
  output logic                err_param,
  output logic                err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LastCmdBit = 4'd9;
  localparam logic [3:0] LastGapBit = 4'(GAP_BITS - 1);
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);
  localparam logic [TW-1:0] IgnoreCycles = TW'(4);

  typedef enum logic [2:0] {
    StIdle, StLoadD, StGap1, StLoadM, StGap2, StGo, StWaitDone, StFinish
  } state_e;

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic [3:0]    bit_q, bit_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    chan_q, chan_d;
  logic [7:0]    m_q, m_d;
  logic [7:0]    d_q, d_d;
  logic          timed_out_q, timed_out_d;
  logic          err_param_q, err_param_d;
  logic          ready_en_q;

  logic          accept;
  logic          bad_req;
  logic          sel_done;
  logic [3:0]    last_bit;
  state_e        after_st;
  logic          drive;
  logic [3:0]    data_idx;

  assign accept  = req_valid && req_ready;
  assign bad_req = ({1'b0, req_chan} >= 5'(N_CLOCKS)) || (req_m == 8'd0);

  // State register; ready_en_q holds req_ready low until one cycle after reset release.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      tcnt_q      <= '0;
      chan_q      <= '0;
      m_q         <= '0;
      d_q         <= '0;
      timed_out_q <= 1'b0;
      err_param_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      tcnt_q      <= tcnt_d;
      chan_q      <= chan_d;
      m_q         <= m_d;
      d_q         <= d_d;
      timed_out_q <= timed_out_d;
      err_param_q <= err_param_d;
      ready_en_q  <= 1'b1;
    end
  end

  // Next-state logic: bit sequencing on the phase-1 cycle of each bit-time, done/timeout wait.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    tcnt_d      = tcnt_q;
    chan_d      = chan_q;
    m_d         = m_q;
    d_d         = d_q;
    timed_out_d = timed_out_q;
    err_param_d = 1'b0;
    last_bit    = LastCmdBit;
    after_st    = StIdle;

    sel_done = 1'b0;
    for (int i = 0; i < int'(N_CLOCKS); i++) begin
      if (chan_q == 4'(i)) sel_done = progdone[i];
    end

    case (state_q)
      StIdle: begin
        phase_d = 1'b0;
        bit_d   = '0;
        tcnt_d  = '0;
        if (accept) begin
          chan_d = req_chan;
          m_d    = req_m;
          d_d    = req_d;
          if (bad_req) err_param_d = 1'b1;
          else         state_d     = StLoadD;
        end
      end
      StLoadD, StGap1, StLoadM, StGap2, StGo: begin
        case (state_q)
          StLoadD: begin last_bit = LastCmdBit; after_st = StGap1;     end
          StGap1:  begin last_bit = LastGapBit; after_st = StLoadM;    end
          StLoadM: begin last_bit = LastCmdBit; after_st = StGap2;     end
          StGap2:  begin last_bit = LastGapBit; after_st = StGo;       end
          default: begin last_bit = 4'd0;       after_st = StWaitDone; end
        endcase
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = after_st;
            tcnt_d  = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StWaitDone: begin
        phase_d = ~phase_q;
        tcnt_d  = (tcnt_q == TimeoutVal) ? tcnt_q : tcnt_q + TW'(1);
        // A PROGDONE seen on the last allowed cycle still counts as success.
        if ((tcnt_q >= IgnoreCycles) && sel_done) begin
          state_d     = StFinish;
          timed_out_d = 1'b0;
        end else if (tcnt_q + TW'(1) == TimeoutVal) begin
          state_d     = StFinish;
          timed_out_d = 1'b1;
        end
      end
      StFinish: begin
        phase_d = 1'b0;
        bit_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state, so they only move on phase-0 entry.
  always_comb begin
    busy      = (state_q != StIdle);
    req_ready = (state_q == StIdle) && ready_en_q;
    progclk   = phase_q;
    drive     = (state_q == StLoadD) || (state_q == StLoadM) || (state_q == StGo);
    progen    = '0;
    for (int i = 0; i < int'(N_CLOCKS); i++) begin
      progen[i] = drive && (chan_q == 4'(i));
    end
    data_idx = bit_q - 4'd2;
    case (state_q)
      StLoadD: progdata = (bit_q == 4'd0) ? 1'b1 :
                          (bit_q == 4'd1) ? 1'b0 : d_q[data_idx[2:0]];
      StLoadM: progdata = (bit_q < 4'd2) ? 1'b1 : m_q[data_idx[2:0]];
      default: progdata = 1'b0;
    endcase
    done        = (state_q == StFinish) && !timed_out_q;
    err_timeout = (state_q == StFinish) && timed_out_q;
    err_param   = err_param_q;
  end

endmodule

// File: tb/tb_clk_prog_seq.sv
// Self-checking bench for clk_prog_seq: randomized requests, a scoreboard of expected
// serial bits and completion pulses, and continuous protocol monitors.
module tb_clk_prog_seq;

  localparam int NC        = 4;
  localparam int TO        = 100;
  localparam int GB        = 2;
  localparam int CmdCycles = 2 * (10 + GB + 10 + GB + 1);
  localparam int Never     = 1 << 30;

  typedef struct { int cyc; logic [NC-1:0] en; logic dat; } bit_t;
  typedef struct { int cyc; int kind; } ev_t;  // kind: 0 done, 1 err_param, 2 err_timeout

  logic          CLK, RST_N, req_valid, req_ready;
  logic [3:0]    req_chan;
  logic [7:0]    req_m, req_d;
  logic [NC-1:0] progen, progdone;
  logic          progdata, progclk, busy, done, err_param, err_timeout;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_acc = 0;
  bit_t bq[$];
  ev_t  eq[$];
  int   pd_chan = 0;
  int   pd_at = Never;
  bit   pd_en = 1'b0;

  clk_prog_seq #(.N_CLOCKS(NC), .TIMEOUT(TO), .GAP_BITS(GB)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_m(req_m), .req_d(req_d), .progen(progen),
    .progdata(progdata), .progclk(progclk), .progdone(progdone), .busy(busy),
    .done(done), .err_param(err_param), .err_timeout(err_timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void miss(string name, int exp_cyc);
    tests++;
    fails++;
    $display("FAIL %s: expected at cycle %0d, not seen by cycle %0d", name, exp_cyc, cyc);
  endfunction

  // PROGDONE driver: planned level on the requested channel, random noise elsewhere.
  initial begin
    progdone = '0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < NC; i++) begin
        if (pd_en && i == pd_chan) progdone[i] = (cyc >= pd_at);
        else                       progdone[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: serial bits at progclk rises, completion pulses, and per-cycle invariants.
  initial begin
    logic          pclk_prev;
    logic [NC-1:0] en_prev;
    logic          dat_prev;
    bit            idle_next;
    bit_t          b;
    ev_t           e;
    int            k;
    pclk_prev = 1'b0;
    en_prev   = '0;
    dat_prev  = 1'b0;
    idle_next = 1'b0;
    forever begin
      @(negedge CLK);
      while (bq.size() > 0 && bq[0].cyc < cyc) begin
        miss("bit_rise", bq[0].cyc);
        void'(bq.pop_front());
      end
      while (eq.size() > 0 && eq[0].cyc < cyc) begin
        miss("resp_pulse", eq[0].cyc);
        void'(eq.pop_front());
      end
      if (progclk && !pclk_prev) begin
        if (bq.size() > 0) begin
          b = bq.pop_front();
          check("rise_cycle", 32'(cyc), 32'(b.cyc));
          check("progen_bit", 32'(progen), 32'(b.en));
          check("progdata_bit", 32'(progdata), 32'(b.dat));
        end else begin
          check("progen_wait", 32'(progen), 32'd0);
        end
      end
      if (idle_next) begin
        check("ret_busy", 32'(busy), 32'd0);
        check("ret_ready", 32'(req_ready), 32'd1);
        idle_next = 1'b0;
      end
      if (done || err_param || err_timeout) begin
        check("pulse_excl", 32'(done) + 32'(err_param) + 32'(err_timeout), 32'd1);
        k = done ? 0 : (err_param ? 1 : 2);
        if (eq.size() > 0) begin
          e = eq.pop_front();
          check("resp_kind", 32'(k), 32'(e.kind));
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
        end else begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected: pulse kind %0d, expected none (cycle %0d)", k, cyc);
        end
        if (k == 1) begin
          check("param_busy", 32'(busy), 32'd0);
          check("param_progclk", 32'(progclk), 32'd0);
        end else begin
          check("fin_busy", 32'(busy), 32'd1);
          idle_next = 1'b1;
        end
      end
      check("onehot", 32'($countones(progen) <= 1), 32'd1);
      if (!busy) check("idle_quiet", {30'd0, (progen != '0), progclk}, 32'd0);
      if (progclk) check("phase1_stable", {27'd0, progen, progdata}, {27'd0, en_prev, dat_prev});
      pclk_prev = progclk;
      en_prev   = progen;
      dat_prev  = progdata;
    end
  end

  task automatic push_bit(input int a, inout int t, input logic [NC-1:0] en, input logic dat);
    bit_t b;
    b.cyc = a + 2 + 2 * t;
    b.en  = en;
    b.dat = dat;
    bq.push_back(b);
    t++;
  endtask

  // Issue one request; on accept, push the expected bit stream and completion event.
  task automatic do_req(input int chan, input int m, input int d, input int pd_off,
                        input bit keep);
    int            n;
    int            a;
    int            e;
    int            s;
    int            t;
    ev_t           ev;
    logic [9:0]    wd;
    logic [9:0]    wm;
    logic [NC-1:0] oh;
    n = 0;
    req_valid = 1'b1;
    req_chan  = 4'(chan);
    req_m     = 8'(m);
    req_d     = 8'(d);
    while (!req_ready && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_wait: req_ready stayed 0 for %0d cycles", n);
      req_valid = 1'b0;
      return;
    end
    a = cyc;
    last_acc = a;
    if (chan >= NC || m == 0) begin
      ev.cyc  = a + 1;
      ev.kind = 1;
      eq.push_back(ev);
    end else begin
      oh = '0;
      oh[chan] = 1'b1;
      wd = {8'(d), 2'b01};
      wm = {8'(m), 2'b11};
      t = 0;
      for (int i = 0; i < 10; i++) push_bit(a, t, oh, wd[i]);
      for (int i = 0; i < GB; i++) push_bit(a, t, '0, 1'b0);
      for (int i = 0; i < 10; i++) push_bit(a, t, oh, wm[i]);
      for (int i = 0; i < GB; i++) push_bit(a, t, '0, 1'b0);
      push_bit(a, t, oh, 1'b0);
      e = a + 1 + CmdCycles;
      if (pd_off == Never) begin
        ev.cyc  = e + TO;
        ev.kind = 2;
        pd_at   = Never;
      end else begin
        pd_at = e + pd_off;
        s = (pd_at < e + 4) ? e + 4 : pd_at;
        if (s <= e + TO - 1) begin
          ev.cyc  = s + 1;
          ev.kind = 0;
        end else begin
          ev.cyc  = e + TO;
          ev.kind = 2;
        end
      end
      eq.push_back(ev);
      pd_chan = chan;
      pd_en   = 1'b1;
    end
    @(negedge CLK);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((eq.size() != 0 || bq.size() != 0 || busy) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: still busy after %0d cycles", n);
    end
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_progen"}, 32'(progen), 32'd0);
    check({tag, "_outs"}, {25'd0, progdata, progclk, req_ready, busy, done, err_param,
          err_timeout}, 32'd0);
  endtask

  initial begin
    int chan;
    int m;
    int d;
    int pd;
    int r;
    bit keep;
    RST_N     = 1'b0;
    req_valid = 1'b0;
    req_chan  = '0;
    req_m     = '0;
    req_d     = '0;
    repeat (3) @(negedge CLK);
    chk_reset_vals("reset");
    RST_N = 1'b1;
    check("ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("ready_after_rel", 32'(req_ready), 32'd1);

    // Reference request; PROGDONE raised at A+53, first sampled at A+55.
    do_req(2, 'h0B, 'h02, 2, 1'b0);
    wait_idle();
    // Parameter errors.
    do_req(2, 0, 5, 0, 1'b0);
    do_req(5, 3, 3, 0, 1'b0);
    wait_idle();
    // Timeout and the edges of the sample window.
    do_req(1, 7, 9, Never, 1'b0);
    wait_idle();
    do_req(3, 'hFF, 'h00, TO - 1, 1'b0);
    wait_idle();
    do_req(0, 1, 'hA5, TO, 1'b0);
    wait_idle();
    do_req(1, 'h80, 'h5A, -10, 1'b0);
    wait_idle();

    // Reset mid LOAD_M abandons the command.
    do_req(1, 'h33, 'h44, Never, 1'b0);
    while (cyc < last_acc + 29) @(negedge CLK);
    #1;
    RST_N = 1'b0;
    bq.delete();
    eq.delete();
    pd_en = 1'b0;
    @(negedge CLK);
    chk_reset_vals("midreset");
    @(negedge CLK);
    RST_N = 1'b1;
    check("ready_midreset", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("ready_rel2", 32'(req_ready), 32'd1);
    do_req(2, 'h0B, 'h02, 2, 1'b0);
    wait_idle();

    // Back-to-back with req_valid held.
    do_req(0, 'h20, 'h10, 6, 1'b1);
    do_req(3, 'h05, 'h7F, 30, 1'b0);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      chan = int'($urandom_range(0, 5));
      m    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      d    = int'($urandom_range(0, 255));
      r    = int'($urandom_range(0, 4));
      case (r)
        0:       pd = Never;
        1:       pd = int'($urandom_range(0, 10)) - 8;
        2:       pd = int'($urandom_range(TO - 3, TO + 1));
        default: pd = int'($urandom_range(0, 40));
      endcase
      keep = ($urandom_range(0, 2) == 0) && (i != 24);
      do_req(chan, m, d, pd, keep);
      if (!keep && $urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
